// File: rtl/onehot_ring_decoder_if.sv
// Sample/result bundle for onehot_ring_decoder: master drives the ring sample, slave returns the registered tracker state.
// No backpressure; the tracker accepts a sample in every cycle i_valid is high.
interface onehot_ring_decoder_if;
   logic       i_valid;
   logic [3:0] i_data;
   logic [1:0] o_index;
   logic       o_dir;
   logic       o_step;
   logic       o_lap;
   logic       o_err;
   logic       o_locked;
   logic [7:0] o_lap_cnt;

   modport master (
      output i_valid, i_data,
      input  o_index, o_dir, o_step, o_lap, o_err, o_locked, o_lap_cnt
   );

   modport slave (
      input  i_valid, i_data,
      output o_index, o_dir, o_step, o_lap, o_err, o_locked, o_lap_cnt
   );
endinterface

// File: rtl/onehot_ring_decoder.sv
// One-hot ring position tracker; all outputs registered, 1-cycle latency, no backpressure (every valid sample accepted).
// RING_LAP_CNT_EN compiles in the 8-bit wrapping lap counter; without it o_lap_cnt is tied to 0.
module onehot_ring_decoder (
   input  logic                   clk,
   input  logic                   i_rst,
   onehot_ring_decoder_if.slave   bus
);

   typedef enum logic {ST_UNLOCK = 1'b0, ST_LOCK = 1'b1} state_t;

   state_t     r_state;
   logic [1:0] r_index;
   logic       r_dir;
   logic       r_step;
   logic       r_lap;
   logic       r_err;

   state_t     w_state_nxt;
   logic [1:0] w_index_nxt;
   logic       w_dir_nxt;
   logic       w_step_nxt;
   logic       w_lap_nxt;
   logic       w_err_nxt;
   logic       w_onehot;
   logic [1:0] w_new_idx;
   logic [1:0] w_idx_dec;
   logic [1:0] w_idx_inc;

   always_comb begin
      w_onehot  = 1'b1;
      w_new_idx = 2'd0;
      case (bus.i_data)
         4'b0001: w_new_idx = 2'd0;
         4'b0010: w_new_idx = 2'd1;
         4'b0100: w_new_idx = 2'd2;
         4'b1000: w_new_idx = 2'd3;
         default: w_onehot  = 1'b0;
      endcase
   end

   // 2-bit arithmetic gives the mod-4 ring neighbours for free
   assign w_idx_dec = r_index - 2'd1;
   assign w_idx_inc = r_index + 2'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_index_nxt = r_index;
      w_dir_nxt   = r_dir;
      w_step_nxt  = 1'b0;
      w_lap_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      if (bus.i_valid) begin
         case (r_state)
            ST_UNLOCK: begin
               if (w_onehot) begin
                  w_index_nxt = w_new_idx;
                  w_state_nxt = ST_LOCK;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
            ST_LOCK: begin
               if (!w_onehot) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ST_UNLOCK;
               end else if (w_new_idx == r_index) begin
                  w_state_nxt = ST_LOCK;
               end else if (w_new_idx == w_idx_dec) begin
                  w_step_nxt  = 1'b1;
                  w_dir_nxt   = 1'b0;
                  w_index_nxt = w_new_idx;
                  w_lap_nxt   = (w_new_idx == 2'd0);
               end else if (w_new_idx == w_idx_inc) begin
                  w_step_nxt  = 1'b1;
                  w_dir_nxt   = 1'b1;
                  w_index_nxt = w_new_idx;
                  w_lap_nxt   = (w_new_idx == 2'd0);
               end else begin
                  // Distance-2 jump: flag it but resync to the observed position
                  w_err_nxt   = 1'b1;
                  w_index_nxt = w_new_idx;
               end
            end
            default: w_state_nxt = ST_UNLOCK;
         endcase
      end
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_UNLOCK;
         r_index <= 2'd0;
         r_dir   <= 1'b0;
         r_step  <= 1'b0;
         r_lap   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_index <= w_index_nxt;
         r_dir   <= w_dir_nxt;
         r_step  <= w_step_nxt;
         r_lap   <= w_lap_nxt;
         r_err   <= w_err_nxt;
      end
   end

`ifdef RING_LAP_CNT_EN
   logic [7:0] r_lap_cnt;

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_lap_cnt <= 8'd0;
      end else if (w_lap_nxt) begin
         r_lap_cnt <= r_lap_cnt + 8'd1;
      end
   end

   assign bus.o_lap_cnt = r_lap_cnt;
`else
   assign bus.o_lap_cnt = 8'd0;
`endif

   assign bus.o_index  = r_index;
   assign bus.o_dir    = r_dir;
   assign bus.o_step   = r_step;
   assign bus.o_lap    = r_lap;
   assign bus.o_err    = r_err;
   assign bus.o_locked = (r_state == ST_LOCK);

endmodule

// File: tb/tb_onehot_ring_decoder.sv
// Bench for onehot_ring_decoder: vector table plus directed hold/reset/lap sequences, scoreboard-checked.
// Expected lap count follows RING_LAP_CNT_EN the same way the design build does.
module tb_onehot_ring_decoder;

   logic clk;
   logic i_rst;

   onehot_ring_decoder_if bus ();

   onehot_ring_decoder dut (
      .clk   (clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] idx;
      logic       dir;
      logic       stp;
      logic       lap;
      logic       err;
      logic       lck;
      int         laps;
   } exp_t;

   typedef struct {
      logic       v;
      logic [3:0] d;
      exp_t       e;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[16];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic exp_t mk(logic [1:0] idx, logic dir, logic stp, logic lap,
                               logic err, logic lck, int laps);
      exp_t e;
      e.idx = idx; e.dir = dir; e.stp = stp; e.lap = lap;
      e.err = err; e.lck = lck; e.laps = laps;
      return e;
   endfunction

   function automatic int lap_exp(int laps);
`ifdef RING_LAP_CNT_EN
      return laps % 256;
`else
      return 0 * laps;
`endif
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".index"},   int'(bus.o_index),   int'(e.idx));
         chk({tag, ".dir"},     int'(bus.o_dir),     int'(e.dir));
         chk({tag, ".step"},    int'(bus.o_step),    int'(e.stp));
         chk({tag, ".lap"},     int'(bus.o_lap),     int'(e.lap));
         chk({tag, ".err"},     int'(bus.o_err),     int'(e.err));
         chk({tag, ".locked"},  int'(bus.o_locked),  int'(e.lck));
         chk({tag, ".lap_cnt"}, int'(bus.o_lap_cnt), lap_exp(e.laps));
      end
   endtask

   // Called at a falling edge: drive, let one rising edge pass, compare, return at next falling edge
   task automatic apply(input string tag, input logic v, input logic [3:0] d, input exp_t e);
      bus.i_valid = v;
      bus.i_data  = d;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_outputs(tag);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int laps;
      logic [1:0] pos;

      //            v     data      idx  dir  stp  lap  err  lck laps
      vecs[0]  = '{1'b1, 4'b0001, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0)};
      vecs[1]  = '{1'b1, 4'b1000, mk(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0)};
      vecs[2]  = '{1'b1, 4'b0100, mk(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0)};
      vecs[3]  = '{1'b1, 4'b0010, mk(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0)};
      vecs[4]  = '{1'b1, 4'b0001, mk(2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1)};
      vecs[5]  = '{1'b1, 4'b0001, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1)};
      vecs[6]  = '{1'b1, 4'b1000, mk(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1)};
      vecs[7]  = '{1'b1, 4'b0001, mk(2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2)};
      vecs[8]  = '{1'b1, 4'b0100, mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2)};
      vecs[9]  = '{1'b1, 4'b0110, mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2)};
      vecs[10] = '{1'b1, 4'b0000, mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2)};
      vecs[11] = '{1'b0, 4'b1000, mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2)};
      vecs[12] = '{1'b1, 4'b1000, mk(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2)};
      vecs[13] = '{1'b1, 4'b0001, mk(2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3)};
      vecs[14] = '{1'b1, 4'b0010, mk(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3)};
      vecs[15] = '{1'b1, 4'b0011, mk(2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3)};

      bus.i_valid = 1'b0;
      bus.i_data  = 4'b0000;
      i_rst = 1'b1;
      #1;
      chk("reset.index",   int'(bus.o_index),   0);
      chk("reset.locked",  int'(bus.o_locked),  0);
      chk("reset.err",     int'(bus.o_err),     0);
      chk("reset.lap_cnt", int'(bus.o_lap_cnt), 0);
      repeat (2) @(negedge clk);
      i_rst = 1'b0;

      for (int i = 0; i < 16; i++)
         apply($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].e);

      // Relock and bring the lap count to 5
      apply("relock", 1'b1, 4'b0001, mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3));
      apply("up1",    1'b1, 4'b0010, mk(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3));
      apply("down1",  1'b1, 4'b0001, mk(2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4));
      apply("up2",    1'b1, 4'b0010, mk(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4));
      apply("down2",  1'b1, 4'b0001, mk(2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5));

      for (int i = 0; i < 10; i++)
         apply($sformatf("hold%0d", i), 1'b0, 4'($urandom_range(0, 15)),
               mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5));

      // Asynchronous reset between clock edges
      #2;
      i_rst = 1'b1;
      #1;
      chk("async_rst.index",   int'(bus.o_index),   0);
      chk("async_rst.dir",     int'(bus.o_dir),     0);
      chk("async_rst.step",    int'(bus.o_step),    0);
      chk("async_rst.lap",     int'(bus.o_lap),     0);
      chk("async_rst.err",     int'(bus.o_err),     0);
      chk("async_rst.locked",  int'(bus.o_locked),  0);
      chk("async_rst.lap_cnt", int'(bus.o_lap_cnt), 0);
      @(negedge clk);
      i_rst = 1'b0;
      apply("post_rst", 1'b1, 4'b0100, mk(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));

      // 300 laps of right rotation, starting from index 2
      laps = 0;
      pos  = 2'd2;
      while (laps < 300) begin
         pos = pos - 2'd1;
         if (pos == 2'd0) laps++;
         apply("lap_run", 1'b1, 4'(1 << pos),
               mk(pos, 1'b0, 1'b1, (pos == 2'd0), 1'b0, 1'b1, laps));
      end
      chk("lap_cnt_final", int'(bus.o_lap_cnt), lap_exp(300));

      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
